// File: rtl/fetch_prefetch.sv
// Instruction fetch stage: owns the PC, issues word fetches to memory and buffers
// returned instructions in a small FIFO that feeds decode over valid/ready.
module fetch_prefetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 4
) (
  input  logic        clk,
  input  logic        reset,
  output logic        fe_req,
  output logic [31:0] fe_addr,
  input  logic        fe_ack,
  input  logic [31:0] fe_data,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        de_valid,
  input  logic        de_ready,
  output logic [31:0] de_pc,
  output logic [31:0] de_instr
);
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);

  logic [31:0]   pc_q, pc_d;
  logic          inflight_q, inflight_d;
  logic [31:0]   inflight_pc_q, inflight_pc_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;

  logic [31:0] mem_pc    [DEPTH];
  logic [31:0] mem_instr [DEPTH];

  logic        ack, push, pop;
  logic [CW:0] occupancy;

  // Slots already promised (stored + awaiting data); registered state only, so a
  // same-cycle pop never opens an extra request and fe_ack cannot loop back here.
  assign occupancy = {1'b0, count_q} + {{CW{1'b0}}, inflight_q};
  assign fe_req    = ~reset & ~redirect & (occupancy < DEPTH_W);
  assign fe_addr   = pc_q & 32'hFFFF_FFFC;

  assign ack  = fe_req & fe_ack;
  assign push = inflight_q & ~redirect;
  assign pop  = de_valid & de_ready & ~redirect;

  assign de_valid = (count_q != '0);
  assign de_pc    = de_valid ? mem_pc[rd_ptr_q]    : 32'h0;
  assign de_instr = de_valid ? mem_instr[rd_ptr_q] : 32'h0;

  always_comb begin
    pc_d          = pc_q;
    inflight_d    = inflight_q;
    inflight_pc_d = inflight_pc_q;
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    count_d       = count_q;
    if (redirect) begin
      pc_d       = redirect_pc & 32'hFFFF_FFFC;
      inflight_d = 1'b0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
    end else begin
      inflight_d = ack;
      if (ack) begin
        pc_d          = pc_q + 32'd4;
        inflight_pc_d = pc_q;
      end
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      if (push && !pop)      count_d = count_q + 1'b1;
      else if (pop && !push) count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q          <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= 32'h0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      count_q       <= '0;
    end else begin
      pc_q          <= pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      count_q       <= count_d;
    end
  end

  // Storage carries no reset; occupancy is tracked by count/pointers alone.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_pc[wr_ptr_q]    <= inflight_pc_q;
      mem_instr[wr_ptr_q] <= fe_data;
    end
  end

endmodule

// File: tb/tb_fetch_prefetch.sv
// Self-checking bench for fetch_prefetch: directed scenarios plus random traffic,
// all compared against a queue-based model of the fetch/prefetch behaviour.
module tb_fetch_prefetch;
  localparam int DEPTH = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        fe_req;
  logic [31:0] fe_addr;
  logic        fe_ack = 1'b0;
  logic [31:0] fe_data = 32'h0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        de_valid;
  logic        de_ready = 1'b0;
  logic [31:0] de_pc;
  logic [31:0] de_instr;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // Model: next fetch PC, outstanding response, and the FIFO contents as queues.
  logic [31:0] m_pc = RESET_PC;
  bit          m_infl = 1'b0;
  logic [31:0] m_infl_pc = 32'h0;
  logic [31:0] mq_pc[$];
  logic [31:0] mq_ins[$];

  logic        obs_req, obs_valid;
  logic [31:0] obs_addr, obs_pc;

  fetch_prefetch #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .fe_req(fe_req), .fe_addr(fe_addr), .fe_ack(fe_ack), .fe_data(fe_data),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .de_valid(de_valid), .de_ready(de_ready), .de_pc(de_pc), .de_instr(de_instr)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  always @(negedge clk) begin
    if (!reset && dut.count_q > DEPTH) begin
      failures++;
      $display("FAIL overflow count=%0d depth=%0d", dut.count_q, DEPTH);
    end
  end

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  // Drive one cycle (called at posedge+1), check all outputs at negedge, advance model.
  task automatic cycle(input logic rd, input logic [31:0] rpc, input logic ack, input logic rdy);
    logic exp_req, exp_valid;
    logic [31:0] exp_addr, exp_pc, exp_ins;
    redirect = rd; redirect_pc = rpc; fe_ack = ack; de_ready = rdy;
    fe_data = m_infl ? instr_of(m_infl_pc) : $urandom();
    exp_req   = !rd && (mq_pc.size() + int'(m_infl) < DEPTH);
    exp_addr  = m_pc;
    exp_valid = (mq_pc.size() != 0);
    exp_pc    = exp_valid ? mq_pc[0]  : 32'h0;
    exp_ins   = exp_valid ? mq_ins[0] : 32'h0;
    @(negedge clk);
    checks += 5;
    if (fe_req !== exp_req) begin failures++;
      $display("FAIL fe_req cyc=%0d got=%b exp=%b", cyc, fe_req, exp_req); end
    if (fe_addr !== exp_addr) begin failures++;
      $display("FAIL fe_addr cyc=%0d got=%h exp=%h", cyc, fe_addr, exp_addr); end
    if (de_valid !== exp_valid) begin failures++;
      $display("FAIL de_valid cyc=%0d got=%b exp=%b", cyc, de_valid, exp_valid); end
    if (de_pc !== exp_pc) begin failures++;
      $display("FAIL de_pc cyc=%0d got=%h exp=%h", cyc, de_pc, exp_pc); end
    if (de_instr !== exp_ins) begin failures++;
      $display("FAIL de_instr cyc=%0d got=%h exp=%h", cyc, de_instr, exp_ins); end
    obs_req = fe_req; obs_addr = fe_addr; obs_valid = de_valid; obs_pc = de_pc;
    if (rd) begin
      mq_pc.delete(); mq_ins.delete();
      m_infl = 1'b0;
      m_pc = {rpc[31:2], 2'b00};
    end else begin
      if (exp_valid && rdy) begin
        void'(mq_pc.pop_front()); void'(mq_ins.pop_front());
      end
      if (m_infl) begin
        mq_pc.push_back(m_infl_pc); mq_ins.push_back(instr_of(m_infl_pc));
      end
      m_infl = exp_req && ack;
      if (m_infl) begin
        m_infl_pc = m_pc;
        m_pc = m_pc + 32'd4;
      end
    end
    cyc++;
    @(posedge clk); #1;
  endtask

  // Assert reset mid-cycle, check outputs drop at once, release after a clock edge.
  task automatic apply_reset();
    reset = 1'b1; redirect = 1'b0; fe_ack = 1'b1; de_ready = 1'b1;
    #2;
    checks += 4;
    if (de_valid !== 1'b0) begin failures++; $display("FAIL rst_de_valid got=%b exp=0", de_valid); end
    if (fe_req !== 1'b0) begin failures++; $display("FAIL rst_fe_req got=%b exp=0", fe_req); end
    if (de_pc !== 32'h0 || de_instr !== 32'h0) begin failures++;
      $display("FAIL rst_de_data got=%h/%h exp=0/0", de_pc, de_instr); end
    if (fe_addr !== RESET_PC) begin failures++; $display("FAIL rst_fe_addr got=%h exp=%h", fe_addr, RESET_PC); end
    @(posedge clk); #1;
    reset = 1'b0;
    mq_pc.delete(); mq_ins.delete();
    m_infl = 1'b0; m_pc = RESET_PC;
  endtask

  task automatic test_reset();
    @(posedge clk); #1;
    apply_reset();
  endtask

  task automatic test_stream();
    for (int i = 0; i < 10; i++) begin
      cycle(1'b0, 32'h0, 1'b1, 1'b1);
      if (i < 3) begin
        checks++;
        if (obs_addr !== 32'(i * 4) || obs_req !== 1'b1) begin failures++;
          $display("FAIL stream_addr i=%0d got=%h/%b exp=%h/1", i, obs_addr, obs_req, i * 4); end
      end
      if (i == 1 || i == 2) begin
        checks++;
        if (obs_valid !== (i == 2) || (i == 2 && obs_pc !== 32'h0)) begin failures++;
          $display("FAIL stream_latency i=%0d got valid=%b pc=%h", i, obs_valid, obs_pc); end
      end
    end
  endtask

  task automatic test_backpressure();
    int acks = 0;
    cycle(1'b1, 32'h0, 1'b1, 1'b0);
    for (int i = 0; i < 7; i++) begin
      cycle(1'b0, 32'h0, 1'b1, 1'b0);
      if (obs_req) acks++;
    end
    checks += 2;
    if (acks !== 4) begin failures++; $display("FAIL bp_acks got=%0d exp=4", acks); end
    if (obs_req !== 1'b0 || obs_pc !== 32'h0) begin failures++;
      $display("FAIL bp_stall got req=%b pc=%h exp req=0 pc=0", obs_req, obs_pc); end
    cycle(1'b0, 32'h0, 1'b1, 1'b1);
    checks++;
    if (obs_req !== 1'b0) begin failures++; $display("FAIL bp_pop_req got=%b exp=0", obs_req); end
    cycle(1'b0, 32'h0, 1'b1, 1'b1);
    checks++;
    if (obs_req !== 1'b1 || obs_pc !== 32'h4) begin failures++;
      $display("FAIL bp_resume got req=%b pc=%h exp req=1 pc=4", obs_req, obs_pc); end
    for (int i = 0; i < 6; i++) cycle(1'b0, 32'h0, 1'b1, 1'b1);
  endtask

  task automatic test_nack();
    logic ack_pat [5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    cycle(1'b1, 32'h0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      cycle(1'b0, 32'h0, ack_pat[i], 1'b1);
      if (i >= 2) begin
        checks++;
        if (obs_addr !== 32'h8) begin failures++; $display("FAIL nack_hold i=%0d got=%h exp=8", i, obs_addr); end
      end
    end
    for (int i = 0; i < 4; i++) cycle(1'b0, 32'h0, 1'b1, 1'b1);
  endtask

  task automatic test_redirect();
    cycle(1'b1, 32'h0, 1'b0, 1'b1);
    cycle(1'b0, 32'h0, 1'b1, 1'b1);
    cycle(1'b1, 32'h0000_1003, 1'b1, 1'b1);
    cycle(1'b0, 32'h0, 1'b1, 1'b1);
    checks++;
    if (obs_addr !== 32'h1000 || obs_req !== 1'b1 || obs_valid !== 1'b0) begin failures++;
      $display("FAIL redir_restart got addr=%h req=%b valid=%b exp 1000/1/0", obs_addr, obs_req, obs_valid); end
    cycle(1'b0, 32'h0, 1'b1, 1'b1);
    cycle(1'b0, 32'h0, 1'b1, 1'b1);
    checks++;
    if (obs_valid !== 1'b1 || obs_pc !== 32'h1000) begin failures++;
      $display("FAIL redir_first_pc got valid=%b pc=%h exp 1/1000", obs_valid, obs_pc); end
  endtask

  task automatic test_wrap();
    logic [31:0] exp_seq [3] = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000};
    cycle(1'b1, 32'hFFFF_FFF8, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 32'h0, 1'b1, 1'b1);
      checks++;
      if (obs_addr !== exp_seq[i]) begin failures++;
        $display("FAIL wrap_addr i=%0d got=%h exp=%h", i, obs_addr, exp_seq[i]); end
    end
    for (int i = 0; i < 4; i++) cycle(1'b0, 32'h0, 1'b1, 1'b1);
  endtask

  task automatic test_reset_midop();
    cycle(1'b1, 32'h0000_2000, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b0, 32'h0, 1'b1, 1'b0);
    apply_reset();
    cycle(1'b0, 32'h0, 1'b1, 1'b1);
    checks++;
    if (obs_addr !== RESET_PC || obs_valid !== 1'b0) begin failures++;
      $display("FAIL midrst_restart got addr=%h valid=%b exp %h/0", obs_addr, obs_valid, RESET_PC); end
    for (int i = 0; i < 4; i++) cycle(1'b0, 32'h0, 1'b1, 1'b1);
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      cycle($urandom_range(0, 15) == 0, $urandom(), $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0);
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_nack();
    test_redirect();
    test_wrap();
    test_reset_midop();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
